data_mem: RTL
=============

// Module: data_mem
// PURPOSE
//  - Word-organised data memory directly downstream of the ALU. ALU alu_result drives addr; rs2 drives wdata.
//  - Supports RV32I LB/LH/LW/LBU/LHU loads and SB/SH/SW stores.
//  - Reads are combinational so a load completes within the single cycle. Writes commit on the clock edge.
//  - Detects misaligned and illegal accesses and records the first one in sticky error registers.
// PARAMETERS
//  DEPTH   64   number of 32-bit words; must be a power of 2
//  AW      6    word-index width = log2(DEPTH)
// PORTS
//  clk          in   1   system clock; rising edge
//  rst          in   1   asynchronous, active-high reset
//  addr         in   32  byte address (from ALU alu_result)
//  wdata        in   32  store data (rs2); low byte/half used for SB/SH
//  mem_read     in   1   load this cycle
//  mem_write    in   1   store this cycle
//  funct3       in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  rdata        out  32  extended load data; combinational
//  misaligned   out  1   current access is misaligned; combinational
//  illegal      out  1   current access has an unsupported funct3; combinational
//  err_sticky   out  1   registered; set by the first faulting access
//  err_addr     out  32  registered; addr of the first faulting access
// BEHAVIOUR
//  Indexing
//  - Word index = addr[AW+1:2]. Bits above AW+1 are ignored, so addresses wrap modulo 4*DEPTH.
//  - Byte lane = addr[1:0].
//  Qualification (all combinational)
//  - Access = mem_read | mem_write.
//  - misaligned = access & ((H/HU & addr[0]) | (W & addr[1:0]!=0)). Never set when access=0.
//  - illegal = access & funct3 not in {000,001,010,100,101}.
//  - Stores with funct3 100/101 are illegal.
//  - fault = misaligned | illegal.
//  Loads (combinational, zero latency)
//  - rdata = 0 when mem_read=0 or fault=1.
//  - Otherwise the selected lane is extracted and extended:
//    - B: sign-extend bit 7 of the lane.
//    - BU: zero-extend.
//    - H / HU: half selected by addr[1]; sign- or zero-extend.
//    - W: full word.
//  Stores (synchronous)
//  - Occur at posedge clk when mem_write=1 and fault=0.
//  - Byte enables: SB = 1 lane; SH = lanes {addr[1],0..1}; SW = all 4 lanes.
//  - Unenabled lanes keep their old value.
//  - A faulting store writes nothing.
//  Simultaneous events
//  - mem_read=1 & mem_write=1 to the same word: rdata shows the pre-write contents that cycle.
//  - The store still commits at the edge.
//  - A load in the following cycle sees the new data; there is no bypass.
//  Errors (synchronous)
//  - At posedge, if fault=1 and err_sticky=0: err_sticky<=1 and err_addr<=addr.
//  - Later faults do not change err_addr.
//  - Only rst clears err_sticky and err_addr.
//  Reset
//  - rst=1 at any time, including mid-operation, asynchronously does all of the following:
//    - clears every memory word to 0;
//    - sets err_sticky=0 and err_addr=0.
//  - While rst=1: stores are blocked, and rdata returns 0 because memory is cleared.
// STRUCTURE
//  - Shared package/include riscv_defs: localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
//  - The ALU and decoder use the same include.
//  - One combinational sub-module, load_extend: (word, addr[1:0], funct3) -> rdata.
//  - Byte-enable generation, fault logic, memory array and error registers stay in the top level.
// TESTING
//  1. Reset, then LW 0x00 -> rdata=0; err_sticky=0; err_addr=0.
//  2. SW 0x80FF7F01 @0x04; next cycle:
//     - LW @0x04 -> 0x80FF7F01
//     - LB @0x04 -> 0x00000001
//     - LB @0x07 -> 0xFFFFFF80
//     - LBU @0x07 -> 0x00000080
//     - LH @0x06 -> 0xFFFF80FF
//     - LHU @0x06 -> 0x000080FF
//  3. SB 0xAA @0x09, then SH 0x1234 @0x0A (word 2 was 0):
//     - LW @0x08 -> 0x1234AA00
//  4. SW @0x0E -> misaligned=1 same cycle; word 3 unchanged; err_sticky=1; err_addr=0x0E.
//     Then LH @0x01 -> misaligned=1, rdata=0, err_addr stays 0x0E.
//  5. Wrap-around: SW 0xDEADBEEF @(4*DEPTH+0x10) -> LW @0x10 = 0xDEADBEEF.
//     Read and write same word in one cycle -> rdata=old value.
//  6. Stores with funct3=011 and funct3=100 -> illegal=1, no write.
//     Assert rst mid-cycle -> all words, err_sticky and err_addr are 0 immediately, without a clock edge.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - RV32I load/store funct3 encodings shared with the ALU and decoder
package data_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - load/store bus between the execute stage and the data memory
interface data_mem_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        misaligned;
    logic        illegal;
    logic        err_sticky;
    logic [31:0] err_addr;

    modport master (
        output addr, wdata, mem_read, mem_write, funct3,
        input  rdata, misaligned, illegal, err_sticky, err_addr
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write, funct3,
        output rdata, misaligned, illegal, err_sticky, err_addr
    );

endinterface

// File: rtl/data_mem_load_extend.sv
// rtl/data_mem_load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            F3_W:    rdata = word;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-cycle RV32I data memory with fault detection and sticky error capture
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_if.slave    bus
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          access;
    logic          f3_known;
    logic          f3_unsigned;
    logic          misaligned;
    logic          illegal;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   ext;
    logic          err_sticky;
    logic [31:0]   err_addr;

    assign widx = bus.addr[AW+1:2];
    assign lane = bus.addr[1:0];

    always_comb begin
        access      = bus.mem_read | bus.mem_write;
        f3_known    = (bus.funct3 == F3_B)  || (bus.funct3 == F3_H)  ||
                      (bus.funct3 == F3_W)  || (bus.funct3 == F3_BU) ||
                      (bus.funct3 == F3_HU);
        f3_unsigned = (bus.funct3 == F3_BU) || (bus.funct3 == F3_HU);
        // Unsigned widths only exist for loads; a store asking for one is rejected.
        illegal     = access & (~f3_known | (bus.mem_write & f3_unsigned));
        misaligned  = access & ((((bus.funct3 == F3_H) || (bus.funct3 == F3_HU)) & lane[0]) |
                                ((bus.funct3 == F3_W) & (lane != 2'b00)));
        fault       = misaligned | illegal;
    end

    always_comb begin
        be = 4'b0000;
        wd = bus.wdata;
        case (bus.funct3)
            F3_B: begin
                be = 4'b0001 << lane;
                wd = {4{bus.wdata[7:0]}};
            end
            F3_H: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.wdata[15:0]}};
            end
            F3_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (bus.mem_write && !fault) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][b*8 +: 8] <= wd[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_addr   <= 32'h0;
        end else if (fault && !err_sticky) begin
            err_sticky <= 1'b1;
            err_addr   <= bus.addr;
        end
    end

    // Read path sees the array before any same-edge store, so read-during-write returns old data.
    load_extend u_load_extend (
        .word   (mem[widx]),
        .lane   (lane),
        .funct3 (bus.funct3),
        .rdata  (ext)
    );

    assign bus.rdata      = (bus.mem_read && !fault) ? ext : 32'h0;
    assign bus.misaligned = misaligned;
    assign bus.illegal    = illegal;
    assign bus.err_sticky = err_sticky;
    assign bus.err_addr   = err_addr;

endmodule
